// File: rtl/ahb_pkg.sv
// Shared AHB encodings and small decode helpers for the four-slave subsystem.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] SLV1 = 2'd0;
    localparam logic [1:0] SLV2 = 2'd1;
    localparam logic [1:0] SLV3 = 2'd2;
    localparam logic [1:0] SLV4 = 2'd3;

    // NONSEQ and SEQ open a data phase; IDLE and BUSY do not.
    function automatic logic trans_is_active(input logic [1:0] htrans);
        logic active;
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

    // An unknown select falls to the default arm and deselects every slave.
    function automatic logic [3:0] decode_slave(input logic [1:0] sel);
        logic [3:0] onehot;
        case (sel)
            SLV1:    onehot = 4'b0001;
            SLV2:    onehot = 4'b0010;
            SLV3:    onehot = 4'b0100;
            SLV4:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

    function automatic logic resp_is_error(input logic resp);
        return (resp == HRESP_ERROR);
    endfunction

endpackage

// File: rtl/ahb_resp_mux.sv
// Data-phase return mux: routes the owning slave's data/ready/response to the master.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            dp_sel,
    input  logic                  dp_active,
    input  logic [DATA_WIDTH-1:0] hrdata_s1,
    input  logic [DATA_WIDTH-1:0] hrdata_s2,
    input  logic [DATA_WIDTH-1:0] hrdata_s3,
    input  logic [DATA_WIDTH-1:0] hrdata_s4,
    input  logic                  hreadyout_s1,
    input  logic                  hreadyout_s2,
    input  logic                  hreadyout_s3,
    input  logic                  hreadyout_s4,
    input  logic                  hresp_s1,
    input  logic                  hresp_s2,
    input  logic                  hresp_s3,
    input  logic                  hresp_s4,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hready,
    output logic                  hresp
);

    // With no data phase in flight the bus idles as ready/OKAY and slave inputs are ignored.
    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        if (dp_active) begin
            case (dp_sel)
                SLV1: begin
                    hrdata = hrdata_s1;
                    hready = hreadyout_s1;
                    hresp  = hresp_s1;
                end
                SLV2: begin
                    hrdata = hrdata_s2;
                    hready = hreadyout_s2;
                    hresp  = hresp_s2;
                end
                SLV3: begin
                    hrdata = hrdata_s3;
                    hready = hreadyout_s3;
                    hresp  = hresp_s3;
                end
                SLV4: begin
                    hrdata = hrdata_s4;
                    hready = hreadyout_s4;
                    hresp  = hresp_s4;
                end
                default: begin
                    hrdata = '0;
                    hready = 1'b1;
                    hresp  = HRESP_OKAY;
                end
            endcase
        end else begin
            hrdata = '0;
            hready = 1'b1;
            hresp  = HRESP_OKAY;
        end
    end

endmodule

// File: rtl/ahb_decoder.sv
// Four-slave AHB decoder: combinational address-phase HSEL plus data-phase
// ownership tracking that steers the slave response mux.
module ahb_decoder
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [1:0]            sel,
    input  logic [1:0]            htrans,
    output logic                  hsel_1,
    output logic                  hsel_2,
    output logic                  hsel_3,
    output logic                  hsel_4,
    input  logic [DATA_WIDTH-1:0] hrdata_s1,
    input  logic [DATA_WIDTH-1:0] hrdata_s2,
    input  logic [DATA_WIDTH-1:0] hrdata_s3,
    input  logic [DATA_WIDTH-1:0] hrdata_s4,
    input  logic                  hreadyout_s1,
    input  logic                  hreadyout_s2,
    input  logic                  hreadyout_s3,
    input  logic                  hreadyout_s4,
    input  logic                  hresp_s1,
    input  logic                  hresp_s2,
    input  logic                  hresp_s3,
    input  logic                  hresp_s4,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hready,
    output logic                  hresp
);

    logic [3:0] hsel_vec_s;
    logic [1:0] dp_sel_r;
    logic       dp_active_r;

    // Address-phase decode, independent of clock, reset and transfer type.
    always_comb begin
        hsel_vec_s = decode_slave(sel);
    end

    assign hsel_1 = hsel_vec_s[0];
    assign hsel_2 = hsel_vec_s[1];
    assign hsel_3 = hsel_vec_s[2];
    assign hsel_4 = hsel_vec_s[3];

    // Data-phase owner advances only when the current phase completes.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dp_sel_r    <= SLV1;
            dp_active_r <= 1'b0;
        end else if (hready) begin
            dp_sel_r    <= sel;
            dp_active_r <= trans_is_active(htrans);
        end else begin
            dp_sel_r    <= dp_sel_r;
            dp_active_r <= dp_active_r;
        end
    end

    ahb_resp_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_mux (
        .dp_sel       (dp_sel_r),
        .dp_active    (dp_active_r),
        .hrdata_s1    (hrdata_s1),
        .hrdata_s2    (hrdata_s2),
        .hrdata_s3    (hrdata_s3),
        .hrdata_s4    (hrdata_s4),
        .hreadyout_s1 (hreadyout_s1),
        .hreadyout_s2 (hreadyout_s2),
        .hreadyout_s3 (hreadyout_s3),
        .hreadyout_s4 (hreadyout_s4),
        .hresp_s1     (hresp_s1),
        .hresp_s2     (hresp_s2),
        .hresp_s3     (hresp_s3),
        .hresp_s4     (hresp_s4),
        .hrdata       (hrdata),
        .hready       (hready),
        .hresp        (hresp)
    );

endmodule

// File: tb/tb_ahb_decoder.sv
// Self-checking bench for ahb_decoder: directed scenarios plus randomized
// traffic against a slave-ownership reference model.
module tb_ahb_decoder;

    localparam int DW = 32;

    logic          hclk   = 1'b0;
    logic          clk_en = 1'b0;
    logic          hreset = 1'b1;
    logic [1:0]    sel    = 2'b00;
    logic [1:0]    htrans = 2'b00;
    logic [DW-1:0] rd  [4];
    logic          rdy [4];
    logic          rsp [4];

    logic          hsel_1, hsel_2, hsel_3, hsel_4;
    logic [DW-1:0] hrdata;
    logic          hready, hresp;

    int checks = 0;
    int errors = 0;
    // Reference state: 0 = no data phase, 1..4 = slave number owning the data phase.
    int owner  = 0;

    always begin
        #5;
        if (clk_en) hclk = ~hclk;
    end

    ahb_decoder #(.DATA_WIDTH(DW)) dut (
        .hclk         (hclk),
        .hreset       (hreset),
        .sel          (sel),
        .htrans       (htrans),
        .hsel_1       (hsel_1),
        .hsel_2       (hsel_2),
        .hsel_3       (hsel_3),
        .hsel_4       (hsel_4),
        .hrdata_s1    (rd[0]),
        .hrdata_s2    (rd[1]),
        .hrdata_s3    (rd[2]),
        .hrdata_s4    (rd[3]),
        .hreadyout_s1 (rdy[0]),
        .hreadyout_s2 (rdy[1]),
        .hreadyout_s3 (rdy[2]),
        .hreadyout_s4 (rdy[3]),
        .hresp_s1     (rsp[0]),
        .hresp_s2     (rsp[1]),
        .hresp_s3     (rsp[2]),
        .hresp_s4     (rsp[3]),
        .hrdata       (hrdata),
        .hready       (hready),
        .hresp        (hresp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] hs;
        logic [31:0] e_data;
        logic        e_rdy, e_rsp;
        hs = {28'd0, hsel_4, hsel_3, hsel_2, hsel_1};
        check({tag, ".hsel"}, hs, 32'd1 << sel);
        e_data = (owner == 0) ? 32'd0 : rd[owner-1];
        e_rdy  = (owner == 0) ? 1'b1  : rdy[owner-1];
        e_rsp  = (owner == 0) ? 1'b0  : rsp[owner-1];
        check({tag, ".hrdata"}, hrdata, e_data);
        check({tag, ".hready"}, {31'd0, hready}, {31'd0, e_rdy});
        check({tag, ".hresp"},  {31'd0, hresp},  {31'd0, e_rsp});
    endtask

    // One clock: model takes the new owner on the edge if the bus was ready.
    task automatic tick();
        logic cur_ready;
        cur_ready = (owner == 0) ? 1'b1 : rdy[owner-1];
        @(posedge hclk);
        if (hreset)
            owner = 0;
        else if (cur_ready)
            owner = (htrans == 2'b10 || htrans == 2'b11) ? int'(sel) + 1 : 0;
        @(negedge hclk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rd[i]  = 32'h1000_0000 + 32'(i);
            rdy[i] = 1'b1;
            rsp[i] = 1'b0;
        end

        // Decode sweep with the clock stopped.
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #20;
            check("sweep.hsel", {28'd0, hsel_4, hsel_3, hsel_2, hsel_1}, 32'd1 << s);
            check("sweep.onehot", 32'(hsel_1) + 32'(hsel_2) + 32'(hsel_3) + 32'(hsel_4), 32'd1);
        end
        check("reset.hready", {31'd0, hready}, 32'd1);
        check("reset.hrdata", hrdata, 32'd0);

        clk_en = 1'b1;
        @(negedge hclk);
        hreset = 1'b0;

        // Reset while slave 3 stalls a live data phase.
        sel = 2'b10; htrans = 2'b10; rd[2] = 32'hDEAD_0003;
        tick();
        rdy[2] = 1'b0; rsp[2] = 1'b1; htrans = 2'b00;
        #1 check_model("stall3");
        check("stall3.hready_low", {31'd0, hready}, 32'd0);
        #1 hreset = 1'b1; sel = 2'b01; owner = 0;
        #1;
        check("rst.hready", {31'd0, hready}, 32'd1);
        check("rst.hresp",  {31'd0, hresp},  32'd0);
        check("rst.hrdata", hrdata, 32'd0);
        check("rst.hsel2",  {31'd0, hsel_2}, 32'd1);
        tick();
        hreset = 1'b0; rdy[2] = 1'b1; rsp[2] = 1'b0;

        // Read routing to slave 3.
        sel = 2'b10; htrans = 2'b10; rd[2] = 32'hCAFE_0003;
        tick();
        htrans = 2'b00;
        #1 check("read.hrdata", hrdata, 32'hCAFE_0003);
        check("read.hready", {31'd0, hready}, 32'd1);
        check_model("read");

        // Wait state on slave 2 while the address phase moves to slave 4.
        sel = 2'b01; htrans = 2'b10;
        tick();
        rdy[1] = 1'b0; sel = 2'b11; rd[1] = 32'hBEEF_0002; rd[3] = 32'hBEEF_0004;
        for (int c = 0; c < 3; c++) begin
            #1 check("wait.hready", {31'd0, hready}, 32'd0);
            check("wait.hrdata", hrdata, 32'hBEEF_0002);
            tick();
        end
        rdy[1] = 1'b1;
        #1 check("release.hready", {31'd0, hready}, 32'd1);
        tick();
        htrans = 2'b00;
        #1 check("switch.hrdata", hrdata, 32'hBEEF_0004);
        check_model("switch");

        // IDLE to a stalled slave opens no data phase.
        sel = 2'b01; htrans = 2'b00; rdy[1] = 1'b0;
        tick();
        #1 check("idle.hready", {31'd0, hready}, 32'd1);
        check("idle.hrdata", hrdata, 32'd0);
        rdy[1] = 1'b1;

        // Two-cycle ERROR from slave 4.
        sel = 2'b11; htrans = 2'b10;
        tick();
        htrans = 2'b00; rsp[3] = 1'b1; rdy[3] = 1'b0;
        #1 check("err1.hresp", {31'd0, hresp}, 32'd1);
        check("err1.hready", {31'd0, hready}, 32'd0);
        tick();
        rdy[3] = 1'b1;
        #1 check("err2.hresp", {31'd0, hresp}, 32'd1);
        check("err2.hready", {31'd0, hready}, 32'd1);
        tick();
        rsp[3] = 1'b0;
        #1 check("err.done", {31'd0, hresp}, 32'd0);

        // Randomized traffic against the ownership model.
        for (int n = 0; n < 400; n++) begin
            sel    = 2'($urandom_range(0, 3));
            htrans = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                rd[i]  = $urandom;
                rdy[i] = ($urandom_range(0, 3) != 0);
                rsp[i] = ($urandom_range(0, 5) == 0);
            end
            hreset = ($urandom_range(0, 39) == 0);
            if (hreset) owner = 0;
            #1 check_model("rand");
            tick();
        end
        hreset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
